if_id_pipe_reg: RTL and testbench

//   Parametrised IF/ID pipeline register for the VLIW fetch/decode boundary. Carries NUM_SLOTS

---
 rtl/if_id_pipe_reg.sv | 135 +++++++++++++
 tb/tb_if_id_pipe_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: NUM_SLOTS-wide VLIW bundle plus PC+1, valid/ready, 2-entry skid buffer.
// Optional IF_ID_BUBBLE_CNT_EN macro adds a saturating 16-bit count of cycles with no valid bundle.
module if_id_pipe_reg #(
    parameter int                  NUM_SLOTS = 4,
    parameter int                  INSTR_W   = 22,
    parameter int                  PC_W      = 10,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 'h00000C
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_SLOTS*INSTR_W-1:0]   f_instr,
    input  logic [PC_W-1:0]                f_pc_plus,
    input  logic                           f_valid,
    output logic                           f_ready,
    output logic [NUM_SLOTS*INSTR_W-1:0]   d_instr,
    output logic [PC_W-1:0]                d_pc_next,
    output logic                           d_valid,
    input  logic                           d_ready
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    output logic [15:0]                    bubble_cnt
`endif
);

    localparam int                BUS_W      = NUM_SLOTS * INSTR_W;
    localparam logic [BUS_W-1:0]  NOP_BUNDLE = {NUM_SLOTS{NOP_INSTR}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e             state_q;
    logic [BUS_W-1:0]   main_instr_q;
    logic [PC_W-1:0]    main_pc_q;
    logic [BUS_W-1:0]   skid_instr_q;
    logic [PC_W-1:0]    skid_pc_q;
    logic               d_valid_q;
    logic               f_ready_q;

    logic f_acc;
    logic d_acc;

    assign f_acc = f_valid & f_ready_q;
    assign d_acc = d_valid_q & d_ready;

    // d_valid/f_ready are kept as their own flops so neither output sees decode logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_BUNDLE;
            main_pc_q    <= '0;
            skid_instr_q <= NOP_BUNDLE;
            skid_pc_q    <= '0;
            d_valid_q    <= 1'b0;
            f_ready_q    <= 1'b1;
        end else if (flush) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_BUNDLE;
            main_pc_q    <= '0;
            skid_instr_q <= NOP_BUNDLE;
            skid_pc_q    <= '0;
            d_valid_q    <= 1'b0;
            f_ready_q    <= 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (f_acc) begin
                        state_q      <= ST_FULL;
                        main_instr_q <= f_instr;
                        main_pc_q    <= f_pc_plus;
                        d_valid_q    <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (f_acc && d_acc) begin
                        main_instr_q <= f_instr;
                        main_pc_q    <= f_pc_plus;
                    end else if (f_acc) begin
                        state_q      <= ST_SKID;
                        skid_instr_q <= f_instr;
                        skid_pc_q    <= f_pc_plus;
                        f_ready_q    <= 1'b0;
                    end else if (d_acc) begin
                        state_q      <= ST_EMPTY;
                        main_instr_q <= NOP_BUNDLE;
                        main_pc_q    <= '0;
                        d_valid_q    <= 1'b0;
                    end
                end
                ST_SKID: begin
                    // Fetch is blocked here, so draining the skid entry is the only move.
                    if (d_ready) begin
                        state_q      <= ST_FULL;
                        main_instr_q <= skid_instr_q;
                        main_pc_q    <= skid_pc_q;
                        skid_instr_q <= NOP_BUNDLE;
                        skid_pc_q    <= '0;
                        f_ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_EMPTY;
                    main_instr_q <= NOP_BUNDLE;
                    main_pc_q    <= '0;
                    d_valid_q    <= 1'b0;
                    f_ready_q    <= 1'b1;
                end
            endcase
        end
    end

    assign d_instr   = main_instr_q;
    assign d_pc_next = main_pc_q;
    assign d_valid   = d_valid_q;
    assign f_ready   = f_ready_q;

`ifdef IF_ID_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;

    // Survives flush on purpose: it measures decode starvation across redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (!d_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed table, async reset cases and random traffic against a
// queue model, run on three parameterisations (4x22, 1x22, 8x32) sharing one control stream.
module tb_if_id_pipe_reg;

    localparam logic [21:0] NOP22 = 22'h00000C;
    localparam logic [31:0] NOP32 = 32'h0000000C;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         f_valid = 1'b0;
    logic         d_ready = 1'b0;
    logic [87:0]  f_instr4 = '0;
    logic [21:0]  f_instr1;
    logic [255:0] f_instr8;
    logic [9:0]   f_pc = '0;

    logic [87:0]  d_instr4;
    logic [21:0]  d_instr1;
    logic [255:0] d_instr8;
    logic [9:0]   d_pc4, d_pc1, d_pc8;
    logic         d_valid4, d_valid1, d_valid8;
    logic         f_ready4, f_ready1, f_ready8;
`ifdef IF_ID_BUBBLE_CNT_EN
    logic [15:0]  bub4, bub1, bub8;
`endif

    always #5 clk = ~clk;

    assign f_instr1 = f_instr4[21:0];
    always_comb begin
        f_instr8 = '0;
        for (int k = 0; k < 8; k++) f_instr8[k*32 +: 32] = {10'(k), f_instr4[(k%4)*22 +: 22]};
    end

    if_id_pipe_reg u4 (
        .clk(clk), .rst(rst), .flush(flush), .f_instr(f_instr4), .f_pc_plus(f_pc),
        .f_valid(f_valid), .f_ready(f_ready4), .d_instr(d_instr4), .d_pc_next(d_pc4),
        .d_valid(d_valid4), .d_ready(d_ready)
`ifdef IF_ID_BUBBLE_CNT_EN
        , .bubble_cnt(bub4)
`endif
    );

    if_id_pipe_reg #(.NUM_SLOTS(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .f_instr(f_instr1), .f_pc_plus(f_pc),
        .f_valid(f_valid), .f_ready(f_ready1), .d_instr(d_instr1), .d_pc_next(d_pc1),
        .d_valid(d_valid1), .d_ready(d_ready)
`ifdef IF_ID_BUBBLE_CNT_EN
        , .bubble_cnt(bub1)
`endif
    );

    if_id_pipe_reg #(.NUM_SLOTS(8), .INSTR_W(32), .NOP_INSTR(NOP32)) u8 (
        .clk(clk), .rst(rst), .flush(flush), .f_instr(f_instr8), .f_pc_plus(f_pc),
        .f_valid(f_valid), .f_ready(f_ready8), .d_instr(d_instr8), .d_pc_next(d_pc8),
        .d_valid(d_valid8), .d_ready(d_ready)
`ifdef IF_ID_BUBBLE_CNT_EN
        , .bubble_cnt(bub8)
`endif
    );

    // Reference model: the stage is a FIFO of at most two bundles; head is what decode sees.
    typedef struct {
        logic [87:0] i;
        logic [9:0]  pc;
    } bnd_t;
    bnd_t        mq[$];
    logic [15:0] bcnt = '0;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [87:0] mk(input logic [9:0] p);
        logic [87:0] r;
        for (int k = 0; k < 4; k++) r[k*22 +: 22] = {p, 4'(k), 8'hA5};
        return r;
    endfunction

    function automatic logic [255:0] widen(input logic [87:0] b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {10'(k), b[(k%4)*22 +: 22]};
        return r;
    endfunction

    task automatic check_model(input string tag);
        logic        ev, er;
        logic [87:0] e4;
        logic [255:0] e8;
        logic [21:0] e1;
        logic [9:0]  epc;
        ev  = (mq.size() > 0);
        er  = (mq.size() < 2);
        e4  = ev ? mq[0].i : {4{NOP22}};
        e1  = ev ? mq[0].i[21:0] : NOP22;
        e8  = ev ? widen(mq[0].i) : {8{NOP32}};
        epc = ev ? mq[0].pc : 10'd0;
        chk({tag, " u4"}, 320'({d_valid4, f_ready4, d_pc4, d_instr4}), 320'({ev, er, epc, e4}));
        chk({tag, " u1"}, 320'({d_valid1, f_ready1, d_pc1, d_instr1}), 320'({ev, er, epc, e1}));
        chk({tag, " u8"}, 320'({d_valid8, f_ready8, d_pc8, d_instr8}), 320'({ev, er, epc, e8}));
    endtask

    // Called at a negedge; drives one cycle, advances the model across the edge, returns at negedge.
    task automatic step(input logic r, input logic fl, input logic fv, input logic [87:0] fi,
                        input logic [9:0] fpc, input logic dr);
        logic fa, da;
        bnd_t b;
        rst = r; flush = fl; f_valid = fv; f_instr4 = fi; f_pc = fpc; d_ready = dr;
        fa = fv && (mq.size() < 2);
        da = (mq.size() > 0) && dr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            bcnt = '0;
        end else begin
            if (mq.size() == 0 && bcnt != 16'hFFFF) bcnt = bcnt + 16'd1;
            if (fl) begin
                mq.delete();
            end else begin
                if (da) void'(mq.pop_front());
                if (fa) begin
                    b.i = fi; b.pc = fpc;
                    mq.push_back(b);
                end
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        int fl, fv, fpc, dr, edv, efr, epc;
    } vec_t;
    localparam int NV = 22;
    vec_t tbl[NV];

    initial begin
        logic [95:0] rnd;
        logic [87:0] e4;

        tbl = '{
            '{0,1,1,1, 1,1,1}, '{0,1,2,1, 1,1,2}, '{0,1,3,1, 1,1,3}, '{0,1,4,1, 1,1,4},
            '{0,1,5,1, 1,1,5}, '{0,1,6,1, 1,1,6}, '{0,1,7,1, 1,1,7}, '{0,1,8,1, 1,1,8},
            '{0,0,0,1, 0,1,0},
            '{0,1,11,0, 1,1,11}, '{0,1,12,0, 1,0,11}, '{0,1,13,0, 1,0,11},
            '{0,1,13,1, 1,1,12}, '{0,1,13,1, 1,1,13}, '{0,0,0,1, 0,1,0},
            '{0,1,21,0, 1,1,21}, '{0,1,22,0, 1,0,21}, '{1,1,23,0, 0,1,0},
            '{0,0,0,0, 0,1,0},   '{1,1,24,1, 0,1,0},  '{0,1,25,0, 1,1,25},
            '{1,0,0,1, 0,1,0}
        };

        // Asynchronous reset mid-cycle: outputs must settle before any clock edge.
        #3 rst = 1'b1;
        #1;
        mq.delete();
        bcnt = '0;
        check_model("async_reset");
        @(negedge clk);

        for (int n = 0; n < NV; n++) begin
            step(1'b0, 1'(tbl[n].fl), 1'(tbl[n].fv), mk(10'(tbl[n].fpc)), 10'(tbl[n].fpc),
                 1'(tbl[n].dr));
            e4 = (tbl[n].edv != 0) ? mk(10'(tbl[n].epc)) : {4{NOP22}};
            chk($sformatf("table[%0d]", n), 320'({d_valid4, f_ready4, d_pc4, d_instr4}),
                320'({1'(tbl[n].edv), 1'(tbl[n].efr), 10'(tbl[n].epc), e4}));
            check_model($sformatf("table_model[%0d]", n));
        end

        // Reset asserted while both entries are occupied.
        step(1'b0, 1'b0, 1'b1, mk(10'd31), 10'd31, 1'b0);
        step(1'b0, 1'b0, 1'b1, mk(10'd32), 10'd32, 1'b0);
        check_model("skid_before_reset");
        #2 rst = 1'b1;
        #1;
        mq.delete();
        bcnt = '0;
        check_model("reset_mid_stall");
        @(negedge clk);
        step(1'b0, 1'b0, 1'b1, mk(10'd40), 10'd40, 1'b0);
        chk("post_reset_first", 320'({d_valid4, d_pc4}), 320'({1'b1, 10'd40}));
        check_model("post_reset_model");

        for (int n = 0; n < 600; n++) begin
            rnd = {$urandom, $urandom, $urandom};
            step(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rnd[87:0],
                 10'($urandom), ($urandom_range(0, 2) != 0));
            check_model("random");
`ifdef IF_ID_BUBBLE_CNT_EN
            chk("random_bubble", 320'({bub4, bub1, bub8}), 320'({bcnt, bcnt, bcnt}));
`endif
        end

`ifdef IF_ID_BUBBLE_CNT_EN
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, mk(10'd50), 10'd50, 1'b0);
        chk("bubble_five", 320'(bub4), 320'(16'd5));
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("bubble_hold", 320'(bub4), 320'(16'd5));
        for (int n = 0; n < 70000; n++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        chk("bubble_sat", 320'({bub4, bub1, bub8}), 320'({16'hFFFF, 16'hFFFF, 16'hFFFF}));
        step(1'b0, 1'b1, 1'b1, mk(10'd60), 10'd60, 1'b1);
        chk("bubble_flush", 320'(bub4), 320'(16'hFFFF));
        check_model("bubble_end");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
